// File: rtl/reg_lock_file_if.sv
// Decoder/CDB side bundle for the locking register file.
// Master drives addresses, alloc requests and CDB broadcasts.
interface reg_lock_file_if #(
  parameter int DATA_W = 32,
  parameter int LOCK_W = 5,
  parameter int AW     = 5
);
  logic [AW-1:0]     rs1_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [LOCK_W-1:0] rs1_lock;
  logic [AW-1:0]     rs2_addr;
  logic [DATA_W-1:0] rs2_data;
  logic [LOCK_W-1:0] rs2_lock;
  logic              alloc_req;
  logic [AW-1:0]     alloc_rd;
  logic [LOCK_W-1:0] alloc_tag;
  logic              alloc_stall;
  logic [LOCK_W-1:0] cdb_in_index_alu;
  logic [DATA_W-1:0] cdb_in_result_alu;
  logic [LOCK_W-1:0] cdb_in_index_lsm;
  logic [DATA_W-1:0] cdb_in_result_lsm;

  modport master (
    output rs1_addr, rs2_addr,
    output alloc_req, alloc_rd,
    output cdb_in_index_alu, cdb_in_result_alu,
    output cdb_in_index_lsm, cdb_in_result_lsm,
    input  rs1_data, rs1_lock,
    input  rs2_data, rs2_lock,
    input  alloc_tag, alloc_stall
  );

  modport slave (
    input  rs1_addr, rs2_addr,
    input  alloc_req, alloc_rd,
    input  cdb_in_index_alu, cdb_in_result_alu,
    input  cdb_in_index_lsm, cdb_in_result_lsm,
    output rs1_data, rs1_lock,
    output rs2_data, rs2_lock,
    output alloc_tag, alloc_stall
  );
endinterface

// File: rtl/reg_lock_file.sv
// Register file with per-register lock tags, cleared by CDB broadcasts.
// REGLOCK_FORWARD_EN: forward live CDB results to the read ports.
module reg_lock_file #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  parameter int LOCK_W  = 5,
  parameter int TAG_NUM = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  reg_lock_file_if.slave bus
);
  localparam int TW = LOCK_W - 1;
  localparam int AW = $clog2(REG_NUM);
  localparam logic [LOCK_W-1:0] NO_LOCK =
    {1'b1, {TW{1'b0}}};

  logic [DATA_W-1:0] data_q [REG_NUM];
  logic [DATA_W-1:0] data_d [REG_NUM];
  logic [LOCK_W-1:0] lock_q [REG_NUM];
  logic [LOCK_W-1:0] lock_d [REG_NUM];
  logic [TAG_NUM-1:0] free_q, free_d;

  logic          alu_v, lsm_v;
  logic [TW-1:0] alu_t, lsm_t;
  logic [TW-1:0] tag_idx;
  logic          any_free, hazard, fire;

  logic [DATA_W-1:0] rs1_raw_d, rs2_raw_d;
  logic [LOCK_W-1:0] rs1_raw_l, rs2_raw_l;
  logic rs1_h_alu, rs1_h_lsm;
  logic rs2_h_alu, rs2_h_lsm;

  always_comb begin
    alu_v = !bus.cdb_in_index_alu[LOCK_W-1];
    lsm_v = !bus.cdb_in_index_lsm[LOCK_W-1];
    alu_t = bus.cdb_in_index_alu[TW-1:0];
    lsm_t = bus.cdb_in_index_lsm[TW-1:0];

    rs1_raw_d = '0;
    rs1_raw_l = NO_LOCK;
    rs2_raw_d = '0;
    rs2_raw_l = NO_LOCK;
    if (bus.rs1_addr != '0) begin
      rs1_raw_d = data_q[bus.rs1_addr];
      rs1_raw_l = lock_q[bus.rs1_addr];
    end
    if (bus.rs2_addr != '0) begin
      rs2_raw_d = data_q[bus.rs2_addr];
      rs2_raw_l = lock_q[bus.rs2_addr];
    end

    rs1_h_alu = alu_v && rs1_raw_l == bus.cdb_in_index_alu;
    rs1_h_lsm = lsm_v && rs1_raw_l == bus.cdb_in_index_lsm;
    rs2_h_alu = alu_v && rs2_raw_l == bus.cdb_in_index_alu;
    rs2_h_lsm = lsm_v && rs2_raw_l == bus.cdb_in_index_lsm;

`ifdef REGLOCK_FORWARD_EN
    hazard = 1'b0;
    bus.rs1_data = rs1_h_alu ? bus.cdb_in_result_alu
                 : rs1_h_lsm ? bus.cdb_in_result_lsm
                 : rs1_raw_d;
    bus.rs1_lock = (rs1_h_alu || rs1_h_lsm) ? NO_LOCK
                 : rs1_raw_l;
    bus.rs2_data = rs2_h_alu ? bus.cdb_in_result_alu
                 : rs2_h_lsm ? bus.cdb_in_result_lsm
                 : rs2_raw_d;
    bus.rs2_lock = (rs2_h_alu || rs2_h_lsm) ? NO_LOCK
                 : rs2_raw_l;
`else
    // Decoder waits a cycle and picks up the written value instead.
    hazard = rs1_h_alu || rs1_h_lsm
          || rs2_h_alu || rs2_h_lsm;
    bus.rs1_data = rs1_raw_d;
    bus.rs1_lock = rs1_raw_l;
    bus.rs2_data = rs2_raw_d;
    bus.rs2_lock = rs2_raw_l;
`endif

    tag_idx = '0;
    for (int t = TAG_NUM - 1; t >= 0; t--)
      if (free_q[t]) tag_idx = TW'(t);
    any_free = |free_q;

    bus.alloc_stall = !any_free || hazard;
    bus.alloc_tag = NO_LOCK;
    if (any_free && !(bus.alloc_req && bus.alloc_rd == '0))
      bus.alloc_tag = {1'b0, tag_idx};
    fire = bus.alloc_req && !bus.alloc_stall
        && bus.alloc_rd != '0;
  end

  always_comb begin
    free_d = free_q;
    if (lsm_v && int'(lsm_t) < TAG_NUM) free_d[lsm_t] = 1'b1;
    if (alu_v && int'(alu_t) < TAG_NUM) free_d[alu_t] = 1'b1;
    if (fire) free_d[tag_idx] = 1'b0;

    data_d[0] = '0;
    lock_d[0] = NO_LOCK;
    for (int r = 1; r < REG_NUM; r++) begin
      data_d[r] = data_q[r];
      lock_d[r] = lock_q[r];
      if (lsm_v && lock_q[r] == bus.cdb_in_index_lsm) begin
        data_d[r] = bus.cdb_in_result_lsm;
        lock_d[r] = NO_LOCK;
      end
      if (alu_v && lock_q[r] == bus.cdb_in_index_alu) begin
        data_d[r] = bus.cdb_in_result_alu;
        lock_d[r] = NO_LOCK;
      end
      if (fire && bus.alloc_rd == AW'(r))
        lock_d[r] = {1'b0, tag_idx};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      free_q <= '1;
      for (int r = 0; r < REG_NUM; r++) begin
        data_q[r] <= '0;
        lock_q[r] <= NO_LOCK;
      end
    end else begin
      free_q <= free_d;
      for (int r = 0; r < REG_NUM; r++) begin
        data_q[r] <= data_d[r];
        lock_q[r] <= lock_d[r];
      end
    end
  end

  // A broadcast of an already-free tag means a station misbehaved.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!alu_v || !free_q[alu_t]);
      assert (!lsm_v || !free_q[lsm_t]);
    end
  end
endmodule
